// File: rtl/beeper_pkg.sv
// Shared encodings for the beeper: FSM states, request codes and sequence modes.
// The request helpers keep the one-deep pending-slot policy in one place.
package beeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_SINGLE = 2'd1,
        REQ_DOUBLE = 2'd2,
        REQ_ALARM  = 2'd3
    } req_t;

    typedef enum logic {
        MODE_KEY   = 1'b0,
        MODE_ALARM = 1'b1
    } mode_t;

    // DOUBLE beats SINGLE; SINGLE never displaces a held DOUBLE; repeats collapse.
    function automatic req_t merge_req(input req_t held, input req_t incoming);
        if (incoming == REQ_DOUBLE) begin
            return REQ_DOUBLE;
        end
        if ((incoming == REQ_SINGLE) && (held == REQ_NONE)) begin
            return REQ_SINGLE;
        end
        return held;
    endfunction

    function automatic logic [1:0] req_beeps(input req_t req);
        return (req == REQ_DOUBLE) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/beeper_tone_divider.sv
// Square-wave generator for the piezo: restarts high on clear, toggles every
// TONE_DIV enabled cycles, and rests low whenever it is neither cleared nor enabled.
module tone_divider #(
    parameter int TONE_DIV = 12500
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic wave
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [TW-1:0] half_cnt_reg;
    logic          wave_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            half_cnt_reg <= '0;
            wave_reg     <= 1'b0;
        end else if (clear) begin
            half_cnt_reg <= '0;
            wave_reg     <= 1'b1;
        end else if (enable) begin
            if (half_cnt_reg == TW'(TONE_DIV - 1)) begin
                half_cnt_reg <= '0;
                wave_reg     <= ~wave_reg;
            end else begin
                half_cnt_reg <= half_cnt_reg + TW'(1);
            end
        end else begin
            half_cnt_reg <= '0;
            wave_reg     <= 1'b0;
        end
    end

    assign wave = wave_reg;

endmodule

// File: rtl/beeper.sv
// Piezo beep sequencer: single/double key beeps and a repeating alarm cadence,
// with a one-deep pending slot so key clicks during a beep are not lost.
module beeper
    import beeper_pkg::*;
#(
    parameter int TONE_DIV = 12500,
    parameter int PRESCALE = 50000,
    parameter int SHORT_MS = 50,
    parameter int LONG_MS  = 200,
    parameter int GAP_MS   = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic press,
    input  logic press_long,
    input  logic alarm,
    output logic buzzer,
    output logic busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t        state_reg;
    mode_t         mode_reg;
    req_t          pending_reg;
    logic [1:0]    beeps_left_reg;
    logic          busy_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    ms_reg;

    req_t       in_req;
    req_t       eff_pending;
    logic       tick;
    logic [7:0] tone_last_ms;
    logic       tone_done;
    logic       gap_done;
    logic       alarm_cut;
    logic [1:0] beeps_after;
    logic       tone_more;
    logic       idle_start;
    logic       gap_abort;
    logic       gap_go;
    logic       enter_tone;
    logic       enter_gap;
    logic       tone_hold;

    always_comb begin
        in_req = REQ_NONE;
        if (press_long) begin
            in_req = REQ_DOUBLE;
        end else if (press) begin
            in_req = REQ_SINGLE;
        end
    end

    // The slot as it will look after this cycle's pulse is folded in; every
    // decision uses this so a pulse on a boundary cycle is still honoured.
    assign eff_pending  = merge_req(pending_reg, in_req);

    assign tick         = (presc_reg == PW'(PRESCALE - 1));
    assign tone_last_ms = (mode_reg == MODE_ALARM) ? 8'(LONG_MS - 1) : 8'(SHORT_MS - 1);
    assign tone_done    = (state_reg == ST_TONE) && tick && (ms_reg == tone_last_ms);
    assign gap_done     = (state_reg == ST_GAP) && tick && (ms_reg == 8'(GAP_MS - 1));
    assign alarm_cut    = (state_reg == ST_TONE) && (mode_reg == MODE_ALARM) && !alarm;

    assign beeps_after  = (beeps_left_reg == 2'd0) ? 2'd0 : (beeps_left_reg - 2'd1);
    assign tone_more    = (beeps_after != 2'd0) || (eff_pending != REQ_NONE) ||
                          ((mode_reg == MODE_ALARM) && alarm);

    assign idle_start   = (state_reg == ST_IDLE) && (alarm || (eff_pending != REQ_NONE));
    // Alarm dropped during its gap with nothing queued: nothing left to play.
    assign gap_abort    = (beeps_left_reg == 2'd0) && !alarm && (eff_pending == REQ_NONE);
    assign gap_go       = gap_done && !gap_abort;

    assign enter_tone   = idle_start || gap_go;
    assign enter_gap    = alarm_cut ? (eff_pending != REQ_NONE) : (tone_done && tone_more);
    assign tone_hold    = (state_reg == ST_TONE) && !tone_done && !alarm_cut;

    // Millisecond timebase restarts on every TONE/GAP entry so durations are exact.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_reg <= '0;
            ms_reg    <= '0;
        end else if (enter_tone || enter_gap || (state_reg == ST_IDLE)) begin
            presc_reg <= '0;
            ms_reg    <= '0;
        end else if (tick) begin
            presc_reg <= '0;
            ms_reg    <= ms_reg + 8'd1;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= MODE_KEY;
            pending_reg    <= REQ_NONE;
            beeps_left_reg <= 2'd0;
            busy_reg       <= 1'b0;
        end else begin
            pending_reg <= eff_pending;
            case (state_reg)
                ST_IDLE: begin
                    if (alarm) begin
                        state_reg      <= ST_TONE;
                        mode_reg       <= MODE_ALARM;
                        beeps_left_reg <= 2'd0;
                        busy_reg       <= 1'b1;
                    end else if (eff_pending != REQ_NONE) begin
                        state_reg      <= ST_TONE;
                        mode_reg       <= MODE_KEY;
                        beeps_left_reg <= req_beeps(eff_pending);
                        pending_reg    <= REQ_NONE;
                        busy_reg       <= 1'b1;
                    end
                end
                ST_TONE: begin
                    if (alarm_cut) begin
                        beeps_left_reg <= 2'd0;
                        state_reg      <= enter_gap ? ST_GAP : ST_IDLE;
                        busy_reg       <= enter_gap;
                    end else if (tone_done) begin
                        beeps_left_reg <= beeps_after;
                        state_reg      <= tone_more ? ST_GAP : ST_IDLE;
                        busy_reg       <= tone_more;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        if (gap_abort) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_TONE;
                            busy_reg  <= 1'b1;
                            if (beeps_left_reg != 2'd0) begin
                                beeps_left_reg <= beeps_left_reg;
                            end else if (alarm) begin
                                mode_reg       <= MODE_ALARM;
                                beeps_left_reg <= 2'd0;
                            end else begin
                                mode_reg       <= MODE_KEY;
                                beeps_left_reg <= req_beeps(eff_pending);
                                pending_reg    <= REQ_NONE;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    tone_divider #(
        .TONE_DIV(TONE_DIV)
    ) u_tone_divider (
        .clock (clock),
        .reset (reset),
        .clear (enter_tone),
        .enable(tone_hold),
        .wave  (buzzer)
    );

    assign busy = busy_reg;

endmodule

// File: tb/tb_beeper.sv
// Directed scenarios for beeper; each stimulus cycle queues the hand-derived
// buzzer/busy values and a negedge monitor compares them against the DUT.
module tb_beeper;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic press = 1'b0;
    logic press_long = 1'b0;
    logic alarm = 1'b0;
    logic buzzer;
    logic busy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic buz;
        logic busy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    localparam int K_IDLE = 0;
    localparam int K_TONE = 1;
    localparam int K_GAP  = 2;

    beeper #(
        .TONE_DIV(2),
        .PRESCALE(4),
        .SHORT_MS(3),
        .LONG_MS (5),
        .GAP_MS  (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .press     (press),
        .press_long(press_long),
        .alarm     (alarm),
        .buzzer    (buzzer),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // n cycles with constant inputs; the expected outputs of each cycle are
    // queued as it starts. Tone pattern with TONE_DIV=2 is 1,1,0,0 from phase ph.
    task automatic run(input int n, input logic p, input logic pl, input logic al,
                       input logic rs, input int kind, input int ph, input string nm);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            case (kind)
                K_TONE:  e = '{buz: ((((ph + i) / 2) % 2) == 0), busy: 1'b1};
                K_GAP:   e = '{buz: 1'b0, busy: 1'b1};
                default: e = '{buz: 1'b0, busy: 1'b0};
            endcase
            exp_q.push_back(e);
            name_q.push_back(nm);
            press      = p;
            press_long = pl;
            alarm      = al;
            reset      = rs;
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if ((buzzer !== e.buz) || (busy !== e.busy)) begin
                failures++;
                $display("FAIL %s t=%0t: buzzer=%b busy=%b, expected buzzer=%b busy=%b",
                         nm, $time, buzzer, busy, e.buz, e.busy);
            end
        end
    end

    initial begin
        // Reset held 3 cycles, then quiet
        run(3, 0, 0, 0, 1, K_IDLE, 0, "reset_hold");
        run(8, 0, 0, 0, 0, K_IDLE, 0, "reset_release");
        $display("scenario reset: done");

        // Single beep: 12 tone cycles then silence
        run(1, 1, 0, 0, 0, K_IDLE, 0, "single_pulse");
        run(12, 0, 0, 0, 0, K_TONE, 0, "single_tone");
        run(4, 0, 0, 0, 0, K_IDLE, 0, "single_after");
        $display("scenario single: done");

        // Double beep: tone 12, gap 8, tone 12 -> busy 32
        run(1, 0, 1, 0, 0, K_IDLE, 0, "double_pulse");
        run(12, 0, 0, 0, 0, K_TONE, 0, "double_tone1");
        run(8, 0, 0, 0, 0, K_GAP, 0, "double_gap");
        run(12, 0, 0, 0, 0, K_TONE, 0, "double_tone2");
        run(4, 0, 0, 0, 0, K_IDLE, 0, "double_after");
        $display("scenario double: done");

        // Pending slot: press during tone, then press_long upgrades it to DOUBLE
        run(1, 1, 0, 0, 0, K_IDLE, 0, "pend_pulse");
        run(3, 0, 0, 0, 0, K_TONE, 0, "pend_tone1");
        run(1, 1, 0, 0, 0, K_TONE, 3, "pend_press");
        run(1, 0, 0, 0, 0, K_TONE, 4, "pend_tone1");
        run(1, 0, 1, 0, 0, K_TONE, 5, "pend_long");
        run(6, 0, 0, 0, 0, K_TONE, 6, "pend_tone1");
        run(8, 0, 0, 0, 0, K_GAP, 0, "pend_gap1");
        run(12, 0, 0, 0, 0, K_TONE, 0, "pend_tone2");
        run(8, 0, 0, 0, 0, K_GAP, 0, "pend_gap2");
        run(12, 0, 0, 0, 0, K_TONE, 0, "pend_tone3");
        run(4, 0, 0, 0, 0, K_IDLE, 0, "pend_after");
        $display("scenario pending: done");

        // Alarm high for 40 cycles: tone 20, gap 8, tone cut after 12
        run(1, 0, 0, 1, 0, K_IDLE, 0, "alarm_rise");
        run(20, 0, 0, 1, 0, K_TONE, 0, "alarm_tone1");
        run(8, 0, 0, 1, 0, K_GAP, 0, "alarm_gap");
        run(11, 0, 0, 1, 0, K_TONE, 0, "alarm_tone2");
        run(1, 0, 0, 0, 0, K_TONE, 11, "alarm_fall");
        run(4, 0, 0, 0, 0, K_IDLE, 0, "alarm_cut");
        $display("scenario alarm: done");

        // press+press_long together, a queued press, then reset mid-tone
        run(1, 1, 1, 0, 0, K_IDLE, 0, "rst_both");
        run(3, 0, 0, 0, 0, K_TONE, 0, "rst_tone");
        run(1, 1, 0, 0, 0, K_TONE, 3, "rst_queue");
        run(1, 0, 0, 0, 0, K_TONE, 4, "rst_tone");
        run(1, 0, 0, 0, 1, K_TONE, 5, "rst_assert");
        run(1, 0, 0, 0, 1, K_IDLE, 0, "rst_held");
        run(40, 0, 0, 0, 0, K_IDLE, 0, "rst_silent");
        $display("scenario reset_mid_tone: done");

        @(posedge clock);
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/beeper.md
# beeper

Audible-feedback driver for the clock's piezo buzzer, on the output side of the user interface. It consumes the one-cycle press and long-press pulses from the button blocks and an alarm level from the timekeeping logic. It plays fixed beep patterns as a square-wave tone: single beep, double beep, or a repeating alarm cadence. One pending request is buffered so that key clicks arriving during a beep are not lost.

## Interface
- TONE_DIV, 12500, clock cycles per buzzer half-period (2 kHz at 50 MHz)
- PRESCALE, 50000, clock cycles per millisecond tick
- SHORT_MS, 50, key-beep tone length in ms (1..255)
- LONG_MS, 200, alarm tone length in ms (1..255)
- GAP_MS, 50, silence between consecutive tones in ms (1..255)
- clock  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- press  input  1  one-cycle pulse requesting a single beep
- press_long  input  1  one-cycle pulse requesting a double beep
- alarm  input  1  level; while high, repeat the alarm cadence
- buzzer  output  1  registered square wave to the piezo; 0 when silent
- busy  output  1  registered; 1 whenever state is not IDLE

## Operation
- States: IDLE, TONE, GAP. A beeps_left counter (2 bits) and a mode flag (KEY or ALARM) qualify the active sequence.
- Request encoding: NONE, SINGLE (1 tone of SHORT_MS), DOUBLE (2 tones of SHORT_MS), ALARM (LONG_MS tones repeated).
- Priority on the same cycle: alarm > press_long > press. If press and press_long arrive together, the result is DOUBLE.
- IDLE: if alarm is high, go to TONE in ALARM mode. Otherwise, if a pending request or input pulse exists, go to TONE in KEY mode with beeps_left = 1 or 2, and clear the pending slot.
- TONE: on duration expiry, decrement beeps_left. Go to GAP if beeps_left > 0, pending is not NONE, or mode is ALARM with alarm still high. Otherwise go to IDLE.
- GAP: after GAP_MS, go to TONE. Request selection:
  - if beeps_left > 0, continue the current sequence;
  - else if alarm is high, switch to ALARM mode;
  - else load the pending request.
- Pending slot, one deep. A pulse arriving while not IDLE is written to the slot:
  - DOUBLE overwrites SINGLE;
  - SINGLE does not overwrite DOUBLE;
  - a second identical request is dropped.
- Alarm deassertion while in ALARM mode: the tone stops immediately. The block goes to GAP if pending is not NONE, else to IDLE. An alarm rising during a KEY sequence takes effect only after that sequence finishes.
- Tone generation:
  - the half-period counter is cleared on every TONE entry;
  - buzzer = 1 on the first TONE cycle and toggles every TONE_DIV cycles;
  - buzzer = 0 in IDLE and GAP.

## Timing
- Reset: state IDLE, buzzer 0, busy 0, pending NONE, beeps_left 0, all counters 0. Reset mid-tone forces buzzer 0 on the next edge.
- Latency: a pulse sampled at edge t in IDLE gives buzzer = 1 and busy = 1 from edge t+1.
- Durations are exact:
  - the prescaler and ms counter clear on each TONE or GAP entry;
  - TONE lasts N×PRESCALE cycles and GAP lasts GAP_MS×PRESCALE cycles;
  - there are no idle cycles between states.
- Widths:
  - prescaler: $clog2(PRESCALE) bits, wrapping at PRESCALE-1;
  - tone counter: $clog2(TONE_DIV) bits;
  - ms counter: 8 bits.
- busy falls on the edge after the last TONE cycle when nothing follows.

## Structure
- The shared package holds the state encodings (IDLE/TONE/GAP), the request codes (NONE/SINGLE/DOUBLE/ALARM) and the mode codes.
- One sub-module, tone_divider, contains the half-period counter and the toggle flop, with inputs clock, reset, clear and enable, and output wave.
- The prescaler, ms counter, FSM and pending slot live in beeper.

## Test plan
All scenarios use PRESCALE=4, TONE_DIV=2, SHORT_MS=3, LONG_MS=5, GAP_MS=2.
- Reset held 3 cycles, then released with inputs low -> buzzer 0 and busy 0 throughout.
- press pulse at cycle 10 -> buzzer 1,1,0,0,… from cycle 11; busy high for cycles 11–22 (12 cycles); buzzer 0 from cycle 23.
- press_long pulse -> 12 cycles tone, 8 cycles silence, 12 cycles tone; busy high for exactly 32 cycles.
- press at cycle 10, then press at cycle 14 and press_long at cycle 16 -> first beep of 12 cycles, gap of 8, then a double beep; total busy = 12+8+32 = 52 cycles.
- alarm high for 40 cycles -> repeating pattern of tone 20, gap 8, tone 12. The second tone is cut when alarm falls, buzzer 0 the next cycle and busy 0 the next cycle.
- press and press_long asserted on the same cycle, then reset asserted mid-tone -> double-beep starts; on reset, buzzer 0, busy 0 and pending NONE on the next edge; no beep after reset release.
